// File: rtl/reg_out_display.sv
// reg_out_display: shows the CPU OUT byte on a 4-digit multiplexed
// seven-segment display. A sequential shift-add-3 converter produces
// unsigned decimal digits, or the byte is shown as two hex digits.
// The conversion runs in both modes, so the update latency does not
// depend on the selected mode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | display stable, compare captured input with last shown
// S_LOAD  | latch value/mode being converted, seed shift register
// S_SHIFT | eight add-3/shift iterations building BCD in shift[19:8]
// S_DONE  | copy digits (decimal or hex) into the display registers
module reg_out_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] VAL,
  input  logic       MODE,
  output logic       BUSY,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  // Display digits are stored as {blank, nibble}; bit 4 set means dark.
  localparam logic [4:0] DIG_BLANK = 5'h10;
  localparam logic [4:0] DIG_ZERO  = 5'h00;

  logic [7:0]    r_val_q;
  logic          r_mode_q;
  logic [7:0]    r_last_val;
  logic          r_last_mode;
  logic [1:0]    r_state;
  logic [19:0]   r_shift;
  logic [2:0]    r_cnt;
  logic [4:0]    r_d3;
  logic [4:0]    r_d2;
  logic [4:0]    r_d1;
  logic [4:0]    r_d0;
  logic [CW-1:0] r_ref;
  logic [1:0]    r_idx;

  logic [19:0]   w_shift_adj;
  logic [19:0]   w_shift_nxt;
  logic [3:0]    w_hund;
  logic [3:0]    w_tens;
  logic [3:0]    w_ones;
  logic [4:0]    w_dig_sel;
  logic [6:0]    w_seg;

  // Capture the CPU OUT bus and mode select every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_val_q  <= 8'd0;
      r_mode_q <= 1'b0;
    end else begin
      r_val_q  <= VAL;
      r_mode_q <= MODE;
    end
  end

  // Add-3 correction on each BCD nibble that would overflow after the shift.
  always_comb begin
    w_shift_adj = r_shift;
    if (r_shift[19:16] >= 4'd5) w_shift_adj[19:16] = r_shift[19:16] + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_shift_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[11:8]  >= 4'd5) w_shift_adj[11:8]  = r_shift[11:8]  + 4'd3;
    w_shift_nxt = {w_shift_adj[18:0], 1'b0};
  end

  assign w_hund = r_shift[19:16];
  assign w_tens = r_shift[15:12];
  assign w_ones = r_shift[11:8];

  // Conversion sequencer; display digits only change in S_DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_last_val  <= 8'd0;
      r_last_mode <= 1'b0;
      r_shift     <= 20'd0;
      r_cnt       <= 3'd0;
      r_d3        <= DIG_BLANK;
      r_d2        <= DIG_BLANK;
      r_d1        <= DIG_BLANK;
      r_d0        <= DIG_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_val_q != r_last_val) || (r_mode_q != r_last_mode)) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_shift     <= {12'd0, r_val_q};
          r_last_val  <= r_val_q;
          r_last_mode <= r_mode_q;
          r_cnt       <= 3'd0;
          r_state     <= S_SHIFT;
        end
        S_SHIFT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_d3 <= DIG_BLANK;
          if (r_last_mode) begin
            r_d2 <= DIG_BLANK;
            r_d1 <= {1'b0, r_last_val[7:4]};
            r_d0 <= {1'b0, r_last_val[3:0]};
          end else begin
            r_d2 <= (w_hund == 4'd0) ? DIG_BLANK : {1'b0, w_hund};
            r_d1 <= ((w_hund == 4'd0) && (w_tens == 4'd0)) ? DIG_BLANK : {1'b0, w_tens};
            r_d0 <= {1'b0, w_ones};
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Refresh timer: advance the scanned digit once per REFRESH_DIV cycles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ref <= '0;
      r_idx <= 2'd0;
    end else if (r_ref == REF_LAST) begin
      r_ref <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_ref <= r_ref + CW'(1);
    end
  end

  // Select the digit for the active anode.
  always_comb begin
    w_dig_sel = r_d0;
    case (r_idx)
      2'd0: w_dig_sel = r_d0;
      2'd1: w_dig_sel = r_d1;
      2'd2: w_dig_sel = r_d2;
      2'd3: w_dig_sel = r_d3;
      default: w_dig_sel = r_d0;
    endcase
  end

  // Seven-segment decode, {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_dig_sel)
      5'h00: w_seg = 7'b1000000;
      5'h01: w_seg = 7'b1111001;
      5'h02: w_seg = 7'b0100100;
      5'h03: w_seg = 7'b0110000;
      5'h04: w_seg = 7'b0011001;
      5'h05: w_seg = 7'b0010010;
      5'h06: w_seg = 7'b0000010;
      5'h07: w_seg = 7'b1111000;
      5'h08: w_seg = 7'b0000000;
      5'h09: w_seg = 7'b0010000;
      5'h0A: w_seg = 7'b0001000;
      5'h0B: w_seg = 7'b0000011;
      5'h0C: w_seg = 7'b1000110;
      5'h0D: w_seg = 7'b0100001;
      5'h0E: w_seg = 7'b0000110;
      5'h0F: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign BUSY = (r_state != S_IDLE);
  assign AN   = ~(4'b0001 << r_idx);
  assign SEG  = w_seg;
  assign DP   = 1'b1;

endmodule

// File: tb/tb_reg_out_display.sv
// Bench for reg_out_display with a short refresh period. Expected display
// contents are pushed to a queue when a value is driven and popped when the
// converter reports completion (BUSY falling).
module tb_reg_out_display;

  logic       CLK;
  logic       RST;
  logic [7:0] VAL;
  logic       MODE;
  logic       BUSY;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] BL = 7'b1111111;
  logic [6:0]  seg_tab [16];
  logic [27:0] sb_q [$];

  reg_out_display #(.REFRESH_DIV(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .VAL  (VAL),
    .MODE (MODE),
    .BUSY (BUSY),
    .AN   (AN),
    .SEG  (SEG),
    .DP   (DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {d3,d2,d1,d0} segment patterns for a value/mode pair.
  function automatic logic [27:0] model(input int v, input logic m);
    int h, t, o;
    logic [6:0] d2, d1;
    if (m) return {BL, BL, seg_tab[v / 16], seg_tab[v % 16]};
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    d2 = (h == 0) ? BL : seg_tab[h];
    d1 = (h == 0 && t == 0) ? BL : seg_tab[t];
    return {BL, d2, d1, seg_tab[o]};
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Collect the segment pattern shown for each anode over one scan period.
  task automatic scan_capture(output logic [27:0] disp);
    int k;
    disp = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      k = an_idx(AN);
      if (k >= 0) disp[k*7 +: 7] = SEG;
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic m);
    @(negedge CLK);
    VAL  = v;
    MODE = m;
    sb_q.push_back(model(int'(v), m));
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_busy(inout int n);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) n++;
      else break;
    end
  endtask

  task automatic test_reset;
    bit ok;
    logic [27:0] disp, e;
    RST = 1'b1; VAL = 8'd0; MODE = 1'b0;
    #3 RST = 1'b0;
    #1;
    n_checks += 4;
    if (BUSY !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    if (AN !== 4'b1110)      begin n_fail++; $display("FAIL reset_an: got %b expected 1110", AN); end
    if (SEG !== 7'b1000000)  begin n_fail++; $display("FAIL reset_seg: got %b expected 1000000", SEG); end
    if (DP !== 1'b1)         begin n_fail++; $display("FAIL reset_dp: got %b expected 1", DP); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    VAL = 8'd200;
    wait_rise(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy_rise: got %b expected 1", ok); end
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    n_checks += 4;
    if (BUSY !== 1'b0)       begin n_fail++; $display("FAIL midshift_busy: got %b expected 0", BUSY); end
    if (AN !== 4'b1110)      begin n_fail++; $display("FAIL midshift_an: got %b expected 1110", AN); end
    if (SEG !== 7'b1000000)  begin n_fail++; $display("FAIL midshift_seg: got %b expected 1000000", SEG); end
    if (DP !== 1'b1)         begin n_fail++; $display("FAIL midshift_dp: got %b expected 1", DP); end
    VAL = 8'd0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n_checks++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: cycle %0d got %b expected 0", i, BUSY); end
    end
    e = model(0, 1'b0);
    scan_capture(disp);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (disp[i*7 +: 7] !== e[i*7 +: 7])
        begin n_fail++; $display("FAIL post_reset_digit%0d: got %b expected %b", i, disp[i*7 +: 7], e[i*7 +: 7]); end
    end
  endtask

  task automatic test_decimal_255;
    bit ok;
    int n;
    logic [27:0] disp, e;
    drive(8'd255, 1'b0);
    wait_rise(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL dec255_busy_rise: got %b expected 1", ok); end
    n = 1;
    count_busy(n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL dec255_busy_len: got %0d expected 10", n); end
    e = sb_q.pop_front();
    scan_capture(disp);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (disp[i*7 +: 7] !== e[i*7 +: 7])
        begin n_fail++; $display("FAIL dec255_digit%0d: got %b expected %b", i, disp[i*7 +: 7], e[i*7 +: 7]); end
    end
  endtask

  task automatic test_blanking;
    bit ok;
    int n;
    logic [27:0] disp, e;
    logic [7:0] vals [2];
    vals[0] = 8'd7;
    vals[1] = 8'd40;
    for (int j = 0; j < 2; j++) begin
      drive(vals[j], 1'b0);
      wait_rise(ok);
      n = 1;
      if (ok) count_busy(n);
      n_checks++;
      if (n != 10 || ok !== 1'b1) begin n_fail++; $display("FAIL blank_busy_len v=%0d: got %0d expected 10", vals[j], n); end
      e = sb_q.pop_front();
      scan_capture(disp);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (disp[i*7 +: 7] !== e[i*7 +: 7])
          begin n_fail++; $display("FAIL blank_v%0d_digit%0d: got %b expected %b", vals[j], i, disp[i*7 +: 7], e[i*7 +: 7]); end
      end
    end
  endtask

  task automatic test_hex;
    bit ok;
    int n;
    logic [27:0] disp, e;
    logic ms [2];
    ms[0] = 1'b1;
    ms[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(8'hA5, ms[j]);
      wait_rise(ok);
      n = 1;
      if (ok) count_busy(n);
      n_checks++;
      if (n != 10 || ok !== 1'b1) begin n_fail++; $display("FAIL hex_busy_len mode=%0d: got %0d expected 10", ms[j], n); end
      e = sb_q.pop_front();
      scan_capture(disp);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (disp[i*7 +: 7] !== e[i*7 +: 7])
          begin n_fail++; $display("FAIL hex_mode%0d_digit%0d: got %b expected %b", ms[j], i, disp[i*7 +: 7], e[i*7 +: 7]); end
      end
    end
  endtask

  task automatic test_midconv;
    bit ok;
    int n, k;
    logic [27:0] disp, e;
    drive(8'd100, 1'b0);
    wait_rise(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_busy_rise: got %b expected 1", ok); end
    n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) n++;
    end
    VAL = 8'd9;
    sb_q.push_back(model(9, 1'b0));
    count_busy(n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL mid_first_busy_len: got %0d expected 10", n); end
    e = sb_q.pop_front();
    // The value 100 stays visible while the second conversion runs.
    for (int s = 0; s < 11; s++) begin
      if (s > 0) @(negedge CLK);
      k = an_idx(AN);
      n_checks++;
      if (k < 0) begin n_fail++; $display("FAIL mid_an_valid: got %b expected one-hot-low", AN); end
      else if (SEG !== e[k*7 +: 7])
        begin n_fail++; $display("FAIL mid_show100_idx%0d: got %b expected %b", k, SEG, e[k*7 +: 7]); end
      if (s == 0 || s == 1) begin
        n_checks++;
        if (BUSY !== (s == 1))
          begin n_fail++; $display("FAIL mid_busy_gap s=%0d: got %b expected %b", s, BUSY, (s == 1)); end
      end
    end
    n = 10;
    count_busy(n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL mid_second_busy_len: got %0d expected 10", n); end
    e = sb_q.pop_front();
    scan_capture(disp);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (disp[i*7 +: 7] !== e[i*7 +: 7])
        begin n_fail++; $display("FAIL mid_final_digit%0d: got %b expected %b", i, disp[i*7 +: 7], e[i*7 +: 7]); end
    end
  endtask

  task automatic test_scan;
    int prev, k, run;
    bit started;
    prev = -1; run = 0; started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      n_checks += 2;
      if ($countones(~AN) != 1) begin n_fail++; $display("FAIL scan_onehot: got %b expected one low bit", AN); end
      if (DP !== 1'b1 || BUSY !== 1'b0)
        begin n_fail++; $display("FAIL scan_dp_busy: got dp=%b busy=%b expected dp=1 busy=0", DP, BUSY); end
      k = an_idx(AN);
      if (k != prev) begin
        if (prev >= 0) begin
          n_checks++;
          if (k != (prev + 1) % 4)
            begin n_fail++; $display("FAIL scan_order: got idx %0d expected %0d", k, (prev + 1) % 4); end
          if (started) begin
            n_checks++;
            if (run != 4) begin n_fail++; $display("FAIL scan_slot_len: got %0d expected 4", run); end
          end
          started = 1'b1;
        end
        prev = k;
        run  = 1;
      end else begin
        run++;
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    test_reset();
    test_decimal_255();
    test_blanking();
    test_hex();
    test_midconv();
    test_scan();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
